// File: rtl/serial2parallel_pkg.sv
// Shared constants and FSM state type for the serial-to-parallel deserializer.
package serial2parallel_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial2parallel_deser_fifo.sv
// Output buffer for completed words: DEPTH-entry FIFO, head word always visible.
module s2p_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push onto a full buffer still lands.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial2parallel_deser.sv
// Collects MSB-first serial bits framed by sof into WIDTH-bit words and buffers them.
module serial2parallel_deser
    import serial2parallel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic             state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             frame_err_q;
    logic             overflow_q;

    logic [WIDTH-1:0] word_d;
    logic             word_done;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign word_d    = {shreg_q[WIDTH-2:0], din};
    assign word_done = (state_q == SHIFT) && din_valid && !sof && (cnt_q == LAST_CNT);
    assign pop       = dout_valid & dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (word_done && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (din_valid && sof) begin
                        shreg_q <= {{(WIDTH-1){1'b0}}, din};
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (din_valid) begin
                        if (sof) begin
                            // Restart on a fresh MSB; the partial word is lost.
                            frame_err_q <= 1'b1;
                            shreg_q     <= {{(WIDTH-1){1'b0}}, din};
                            cnt_q       <= CNT_W'(1);
                        end else if (word_done) begin
                            shreg_q <= word_d;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            shreg_q <= word_d;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    s2p_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (word_done),
        .push_data_i (word_d),
        .pop_i       (pop),
        .head_o      (dout),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign dout_valid = ~fifo_empty;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign state_dbg  = (state_q == SHIFT);

endmodule
